// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned WR_W     = 2;

    // RISC-V funct3 encodings for loads and stores
    localparam logic [FUNCT3_W-1:0] OP_LB  = 3'd0;
    localparam logic [FUNCT3_W-1:0] OP_LH  = 3'd1;
    localparam logic [FUNCT3_W-1:0] OP_LW  = 3'd2;
    localparam logic [FUNCT3_W-1:0] OP_LBU = 3'd4;
    localparam logic [FUNCT3_W-1:0] OP_LHU = 3'd5;
    localparam logic [FUNCT3_W-1:0] OP_SB  = 3'd0;
    localparam logic [FUNCT3_W-1:0] OP_SH  = 3'd1;
    localparam logic [FUNCT3_W-1:0] OP_SW  = 3'd2;

    // Memory write size codes
    localparam logic [WR_W-1:0] WR_NONE = 2'd0;
    localparam logic [WR_W-1:0] WR_BYTE = 2'd1;
    localparam logic [WR_W-1:0] WR_HALF = 2'd2;
    localparam logic [WR_W-1:0] WR_WORD = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: fault check, byte/half/word access, load extension.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned SIZE = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [FUNCT3_W-1:0] req_op,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_fault,
    output logic [XLEN-1:0]     mem_rd_addr,
    input  logic [XLEN-1:0]     mem_rd_data,
    output logic [WR_W-1:0]     mem_wr,
    output logic [XLEN-1:0]     mem_wr_addr,
    output logic [XLEN-1:0]     mem_wr_data
);

    lsu_state_e          state;
    logic [FUNCT3_W-1:0] op_q;

    logic [2:0]          nbytes_c;
    logic [WR_W-1:0]     wr_size_c;
    logic [XLEN-1:0]     wdata_c;
    logic                misalign_c;
    logic                illegal_c;
    logic [XLEN:0]       end_addr_c;
    logic                fault_c;
    logic [XLEN-1:0]     ext_c;

    // Access size, write code, masked store data and alignment from the request funct3
    always_comb begin
        nbytes_c   = 3'd1;
        wr_size_c  = WR_BYTE;
        wdata_c    = {24'b0, req_wdata[7:0]};
        misalign_c = 1'b0;
        case (req_op[1:0])
            2'd1: begin
                nbytes_c   = 3'd2;
                wr_size_c  = WR_HALF;
                wdata_c    = {16'b0, req_wdata[15:0]};
                misalign_c = req_addr[0];
            end
            2'd2: begin
                nbytes_c   = 3'd4;
                wr_size_c  = WR_WORD;
                wdata_c    = req_wdata;
                misalign_c = |req_addr[1:0];
            end
            default: ;
        endcase
    end

    // Reserved funct3 values, and unsigned-load encodings used as stores
    always_comb begin
        case (req_op)
            OP_LB, OP_LH, OP_LW: illegal_c = 1'b0;
            OP_LBU, OP_LHU:      illegal_c = req_we;
            default:             illegal_c = 1'b1;
        endcase
    end

    // One extra bit so addresses near 2^32 cannot wrap past the range check
    assign end_addr_c = {1'b0, req_addr} + (XLEN+1)'(nbytes_c);
    assign fault_c    = illegal_c | misalign_c | (end_addr_c > (XLEN+1)'(SIZE));

    // Sign/zero extension of the captured memory word for the pending load
    always_comb begin
        case (op_q)
            OP_LB:   ext_c = {{24{mem_rd_data[7]}}, mem_rd_data[7:0]};
            OP_LH:   ext_c = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
            OP_LBU:  ext_c = {24'b0, mem_rd_data[7:0]};
            OP_LHU:  ext_c = {16'b0, mem_rd_data[15:0]};
            default: ext_c = mem_rd_data;
        endcase
    end

    // Request/response FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_fault  <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr      <= WR_NONE;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        req_ready <= 1'b0;
                        if (fault_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we) begin
                            state       <= WR;
                            mem_wr      <= wr_size_c;
                            mem_wr_addr <= req_addr;
                            mem_wr_data <= wdata_c;
                        end else begin
                            state       <= RD;
                            mem_rd_addr <= req_addr;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= ext_c;
                end
                WR: begin
                    state      <= RESP;
                    mem_wr     <= WR_NONE;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_wr     <= WR_NONE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

    localparam int unsigned SIZE = 1024;
    localparam int unsigned AW   = $clog2(SIZE);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data = 32'd0;
    logic [1:0]  mem_wr;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    load_store_unit #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr      (mem_wr),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Attached memory (behaves like the real RAM) and the reference copy
    logic [7:0] mem     [SIZE];
    logic [7:0] ref_mem [SIZE];

    function automatic logic [AW-1:0] ix(input logic [31:0] a);
        return AW'(a % 32'(SIZE));
    endfunction

    always @(posedge clk) begin
        mem_rd_data <= {mem[ix(mem_rd_addr + 32'd3)], mem[ix(mem_rd_addr + 32'd2)],
                        mem[ix(mem_rd_addr + 32'd1)], mem[ix(mem_rd_addr)]};
        if (mem_wr != 2'd0)
            for (int i = 0; i < 4; i++)
                if (i < ((mem_wr == 2'd3) ? 4 : int'(mem_wr)))
                    mem[ix(mem_wr_addr + 32'(i))] = mem_wr_data[8*i +: 8];
    end

    // Reference model: access width, fault rules and load result from the ISA rules
    function automatic int nbytes(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit ref_fault(input bit we, input logic [2:0] op, input logic [31:0] addr);
        int     n = nbytes(op);
        longint a = longint'({32'b0, addr});
        if (n == 0) return 1'b1;
        if (we && op >= 3'd4) return 1'b1;
        if (a % n != 0) return 1'b1;
        return (a + n) > longint'(SIZE);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
        int     n = nbytes(op);
        longint v = 0;
        for (int i = 0; i < n; i++)
            v += longint'({56'b0, ref_mem[ix(addr + 32'(i))]}) << (8 * i);
        if (op < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    typedef struct {
        bit          store;
        bit          fault;
        logic [31:0] rdata;
        int          acc_edge;
        int          lat;
        logic [1:0]  wr_code;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
    } exp_t;

    exp_t exp_q[$];

    // Issue one request; 'live' = a response is expected and memory contents change
    task automatic issue(input bit we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit live);
        exp_t e;
        int   n = nbytes(op);
        int   w = 0;
        while (req_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        e.store    = we;
        e.fault    = ref_fault(we, op, addr);
        e.rdata    = 32'd0;
        e.wr_code  = 2'd0;
        e.wr_addr  = 32'd0;
        e.wr_data  = 32'd0;
        e.lat      = e.fault ? 1 : (we ? 2 : 3);
        e.acc_edge = edge_n + 1;
        if (!e.fault && we) begin
            e.wr_code = (n == 4) ? 2'd3 : 2'(n);
            e.wr_addr = addr;
            e.wr_data = (n == 4) ? wdata : (wdata & ((32'd1 << (8 * n)) - 32'd1));
            if (live)
                for (int i = 0; i < n; i++) ref_mem[ix(addr + 32'(i))] = wdata[8*i +: 8];
        end else if (!e.fault) begin
            e.rdata = ref_load(op, addr);
        end
        if (live) exp_q.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // Response-ready driver: always ready, random, or a 5-cycle stall on the next response
    bit rand_rr    = 1'b0;
    bit stall_arm  = 1'b0;
    int stall_left = 0;
    always @(negedge clk) begin
        if (stall_arm && resp_valid) begin
            stall_arm  = 1'b0;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            resp_ready = 1'b0;
            stall_left--;
        end else begin
            resp_ready = rand_rr ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each new response and checks protocol holds
    int          wr_cycles = 0;
    logic [1:0]  wr_code_s = 2'd0;
    logic [31:0] wr_addr_s = 32'd0;
    logic [31:0] wr_data_s = 32'd0;
    bit          prev_rv = 1'b0, prev_rr = 1'b0, prev_hs = 1'b0, prev_fault = 1'b0;
    logic [31:0] prev_rdata = 32'd0;
    exp_t        mon_e;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            wr_cycles = 0;
            prev_rv   = 1'b0;
            prev_rr   = 1'b0;
            prev_hs   = 1'b0;
        end else begin
            if (mem_wr != 2'd0) begin
                wr_cycles++;
                wr_code_s = mem_wr;
                wr_addr_s = mem_wr_addr;
                wr_data_s = mem_wr_data;
            end
            if (prev_hs) begin
                check("after_hs_resp_valid", 32'(resp_valid), 32'd0);
                check("after_hs_req_ready", 32'(req_ready), 32'd1);
            end
            if (prev_rv && !prev_rr) begin
                check("hold_resp_valid", 32'(resp_valid), 32'd1);
                check("hold_resp_rdata", resp_rdata, prev_rdata);
                check("hold_resp_fault", 32'(resp_fault), 32'(prev_fault));
                check("hold_req_ready", 32'(req_ready), 32'd0);
            end
            if (resp_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("latency", 32'(edge_n - mon_e.acc_edge + 1), 32'(mon_e.lat));
                    check("resp_fault", 32'(resp_fault), 32'(mon_e.fault));
                    check("resp_rdata", resp_rdata, mon_e.rdata);
                    check("mem_wr_cycles", 32'(wr_cycles),
                          (mon_e.store && !mon_e.fault) ? 32'd1 : 32'd0);
                    if (mon_e.store && !mon_e.fault) begin
                        check("mem_wr_size", 32'(wr_code_s), 32'(mon_e.wr_code));
                        check("mem_wr_addr", wr_addr_s, mon_e.wr_addr);
                        check("mem_wr_data", wr_data_s, mon_e.wr_data);
                    end
                end
                wr_cycles = 0;
            end
            prev_rv    = resp_valid;
            prev_rr    = resp_ready;
            prev_hs    = resp_valid && resp_ready;
            prev_rdata = resp_rdata;
            prev_fault = resp_fault;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    // Stimulus
    initial begin
        logic [2:0]  op;
        bit          we;
        logic [31:0] a;
        int          n;
        int          w;

        for (int i = 0; i < int'(SIZE); i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset with a request held on the bus: outputs cleared, nothing accepted
        req_valid = 1'b1;
        req_op    = 3'd2;
        req_addr  = 32'h10;
        repeat (3) @(negedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_rd_addr", mem_rd_addr, 32'd0);
        check("rst_mem_wr_addr", mem_wr_addr, 32'd0);
        check("rst_mem_wr_data", mem_wr_data, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Word round trip, extensions, byte store merge
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 3'd4, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b1);
        issue(1'b0, 3'd5, 32'h12, 32'h0, 1'b1);
        issue(1'b1, 3'd0, 32'h11, 32'hA5B6C77F, 1'b1);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);

        // Faults: misaligned, out of range, illegal op
        issue(1'b1, 3'd1, 32'h11, 32'h1234, 1'b1);
        issue(1'b0, 3'd2, 32'h402, 32'h0, 1'b1);
        issue(1'b0, 3'd2, 32'h400, 32'h0, 1'b1);
        issue(1'b0, 3'd1, 32'h3FF, 32'h0, 1'b1);
        issue(1'b0, 3'd3, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 3'd4, 32'h4, 32'h55, 1'b1);

        // Backpressure on an LW response
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
        stall_arm = 1'b1;
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 3'd2, 32'h3FC, 32'h0, 1'b1);

        // Reset during the write cycle of a store: write and response abandoned
        issue(1'b1, 3'd2, 32'h20, 32'h12345678, 1'b0);
        #2;
        check("wr_cycle_before_reset", 32'(mem_wr), 32'd3);
        rst_n = 1'b0;
        #1;
        check("reset_drops_mem_wr", 32'(mem_wr), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_mem_wr_data", mem_wr_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);

        // Randomized traffic with random response backpressure
        rand_rr = 1'b1;
        for (int k = 0; k < 250; k++) begin
            op = 3'($urandom);
            we = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'(SIZE) - 32'($urandom_range(0, 4));
                default: a = 32'($urandom_range(0, SIZE - 1));
            endcase
            n = nbytes(op);
            if (n > 0 && $urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            issue(we, op, a, $urandom, 1'b1);
        end

        // Drain remaining responses
        rand_rr = 1'b0;
        w = 0;
        while ((exp_q.size() != 0 || resp_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        #2;
        check("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        check("stray_mem_writes", 32'(wr_cycles), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter SIZE, default 1024, giving the byte count of the attached memory; the address range is 0..SIZE-1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts a request; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_op, input, 3 bits: RISC-V funct3 (0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU).
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: a response is pending.
REQ-011 The block SHALL have port resp_ready, input, 1 bit: the core takes the response.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and faults.
REQ-013 The block SHALL have port resp_fault, output, 1 bit: the request was rejected and no memory access was made.
REQ-014 The block SHALL have port mem_rd_addr, output, 32 bits: memory read address.
REQ-015 The block SHALL have port mem_rd_data, input, 32 bits: memory read data, little-endian from mem_rd_addr, valid one edge after mem_rd_addr is presented.
REQ-016 The block SHALL have port mem_wr, output, 2 bits: write size (0 none, 1 byte, 2 half, 3 word).
REQ-017 The block SHALL have port mem_wr_addr, output, 32 bits: memory write address.
REQ-018 The block SHALL have port mem_wr_data, output, 32 bits: write data, low bytes first.

Function
REQ-019 The FSM SHALL have states IDLE, RD, CAP, WR and RESP; req_ready SHALL be 1 exactly in IDLE.
REQ-020 Fault check on acceptance:
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
- Out of range: addr+bytes > SIZE.
- Illegal op: op in {3,6,7}, or a store with op in {4,5}.
- A faulting request SHALL go IDLE->RESP with resp_fault=1, resp_rdata=0, mem_wr=0.
REQ-021 Load path: IDLE->RD (mem_rd_addr=req_addr, registered and held) -> CAP -> RESP.
- In CAP, mem_rd_data SHALL be extended and registered into resp_rdata.
- resp_valid SHALL rise 3 edges after the accepting edge.
REQ-022 Extension: LB sign-extends [7:0]; LBU zero-extends [7:0]; LH sign-extends [15:0]; LHU zero-extends [15:0]; LW passes all 32 bits.
REQ-023 Store path: IDLE->WR->RESP.
- In WR, mem_wr SHALL be 1/2/3 for SB/SH/SW for exactly one cycle, mem_wr_addr=req_addr, and mem_wr_data=req_wdata with unused upper bytes forced to 0.
- resp_valid SHALL rise 2 edges after the accepting edge.
REQ-024 mem_wr SHALL be 0 in every state except WR.
REQ-025 In RESP, resp_valid, resp_rdata and resp_fault SHALL be held stable until resp_ready=1; that edge SHALL return the FSM to IDLE with resp_valid=0.
REQ-026 Because a new request is accepted only in IDLE, a store SHALL be fully written before any following load issues.
REQ-027 Request fields SHALL be captured at acceptance; changes on req_* while busy SHALL have no effect.

Reset
REQ-028 While rst_n=0 the block SHALL force state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0, mem_wr=0, mem_rd_addr=0, mem_wr_addr=0 and mem_wr_data=0, asynchronously.
REQ-029 Reset in any state SHALL abandon the operation.
- A store in WR SHALL not reach memory, because mem_wr drops to 0 immediately.
- No response SHALL be produced for the abandoned request.
REQ-030 No request SHALL be accepted while rst_n=0.

Structure
REQ-031 Package lsu_pkg SHALL hold:
- the funct3 op constants;
- the mem_wr size codes WR_NONE, WR_BYTE, WR_HALF, WR_WORD (0..3);
- the FSM state enum.
REQ-032 No sub-module SHALL be instantiated; the extension and fault logic SHALL be inline.

Verification
REQ-033 Word round trip: SW 0xDEADBEEF to 0x10, then LW 0x10.
- Store: mem_wr=3 for one cycle, mem_wr_addr=0x10.
- Load: resp_rdata=0xDEADBEEF, resp_fault=0.
REQ-034 Extension, after REQ-033:
- LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
- LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
- SB 0x7F to 0x11, then LW 0x10 -> 0xDEAD7FEF.
REQ-035 Faults, SIZE=1024, each with resp_fault=1, resp_rdata=0 and mem_wr=0 throughout:
- SH 0x11; LW 0x402; LW 0x400; LH 0x3FF; op=3.
- Each response SHALL arrive 1 edge after acceptance.
REQ-036 Backpressure: resp_ready=0 for 5 cycles after an LW 0x10 response.
- resp_valid=1 and resp_rdata=0xDEADBEEF are held; req_ready=0.
- Release -> IDLE on the next edge.
REQ-037 Reset mid-store: rst_n low during the WR cycle of SW 0x12345678 to 0x20.
- mem_wr=0 immediately; resp_valid=0.
- After release, LW 0x20 returns the prior contents.
REQ-038 Latency: back-to-back LW/SW with resp_ready=1.
- Accept-to-resp_valid is 3 edges for loads and 2 for stores.
- req_ready=1 on the cycle after each response handshake.
